// File: rtl/snake_body_ring_if.sv
// Control/render-side bus of the snake body store: step commands in, status and render read port out.
interface snake_body_ring_if #(
    parameter int XBITS   = 3,
    parameter int YBITS   = 3,
    parameter int MAX_LEN = 64
);
    localparam int PW = XBITS + YBITS;
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic          start;
    logic          step;
    logic          grow;
    logic [1:0]    direction;
    logic          wall_mode;
    logic          busy;
    logic          done;
    logic          collision_self;
    logic          collision_wall;
    logic          full;
    logic [PW-1:0] head;
    logic [LW-1:0] length;
    logic [IW-1:0] rd_idx;
    logic [PW-1:0] rd_pos;
    logic          rd_valid;

    modport master (
        output start, step, grow, direction, wall_mode, rd_idx,
        input  busy, done, collision_self, collision_wall, full, head, length, rd_pos, rd_valid
    );

    modport slave (
        input  start, step, grow, direction, wall_mode, rd_idx,
        output busy, done, collision_self, collision_wall, full, head, length, rd_pos, rd_valid
    );
endinterface

// File: rtl/snake_body_ring.sv
// Circular-buffer snake body: computes the next head, scans the body for self-collision one
// segment per cycle, commits the move (optionally growing) and serves a 1-cycle render read port.
module snake_body_ring #(
    parameter int                         XBITS    = 3,
    parameter int                         YBITS    = 3,
    parameter int                         MAX_LEN  = 64,
    parameter logic [XBITS+YBITS-1:0]     INIT_POS = '0
) (
    input  logic              clock,
    input  logic              restart,
    snake_body_ring_if.slave  bus
);
    localparam int PW = XBITS + YBITS;
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {IDLE, CALC, SCAN, COMMIT, DONE} state_t;

    state_t        state_q;
    logic [PW-1:0] mem_q [MAX_LEN];
    logic [IW-1:0] head_ptr_q, scan_k_q;
    logic [LW-1:0] length_q, scan_len_q;
    logic [PW-1:0] head_q, new_head_q;
    logic          grow_q, wall_q;
    logic [1:0]    dir_q;
    logic          busy_q, done_q, coll_self_q, coll_wall_q;
    logic [PW-1:0] rd_pos_q;
    logic          rd_valid_q;

    // (p - k) mod MAX_LEN; the +MAX_LEN correction keeps non-power-of-2 rings in range
    function automatic logic [IW-1:0] ptr_sub(input logic [IW-1:0] p, input logic [IW-1:0] k);
        if (p >= k) return p - k;
        else        return p - k + IW'(MAX_LEN);
    endfunction

    logic [XBITS-1:0] hx, nx_d;
    logic [YBITS-1:0] hy, ny_d;
    logic             edge_d, eff_grow_d, full_w, seg_hit, scan_last;
    logic [PW-1:0]    new_head_d;
    logic [LW-1:0]    scan_len_d;
    logic [IW-1:0]    head_ptr_d;

    assign hx = head_q[XBITS-1:0];
    assign hy = head_q[PW-1:XBITS];

    always_comb begin
        nx_d   = hx;
        ny_d   = hy;
        edge_d = 1'b0;
        case (dir_q)
            2'b00: begin nx_d = hx + 1'b1; edge_d = &hx;      end
            2'b01: begin ny_d = hy + 1'b1; edge_d = &hy;      end
            2'b10: begin nx_d = hx - 1'b1; edge_d = (hx == '0); end
            default: begin ny_d = hy - 1'b1; edge_d = (hy == '0); end
        endcase
    end

    assign new_head_d = {ny_d, nx_d};
    assign full_w     = (length_q == LW'(MAX_LEN));
    assign eff_grow_d = grow_q & ~full_w;
    // Without growth the tail cell is vacated by this move, so it is excluded from the scan.
    assign scan_len_d = eff_grow_d ? length_q : length_q - 1'b1;
    assign seg_hit    = (mem_q[ptr_sub(head_ptr_q, scan_k_q)] == new_head_q);
    assign scan_last  = (LW'(scan_k_q) == scan_len_q - 1'b1);
    assign head_ptr_d = (head_ptr_q == IW'(MAX_LEN - 1)) ? '0 : head_ptr_q + 1'b1;

    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
            mem_q[0] <= INIT_POS;
        end else if (bus.start) begin
            mem_q[0] <= INIT_POS;
        end else if (state_q == COMMIT) begin
            mem_q[head_ptr_d] <= new_head_q;
        end
    end

    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            state_q <= IDLE;  head_ptr_q <= '0;  length_q <= LW'(1);  head_q <= INIT_POS;
            new_head_q <= '0; scan_len_q <= '0;  scan_k_q <= '0;
            grow_q <= 1'b0;   wall_q <= 1'b0;    dir_q <= 2'b00;
            busy_q <= 1'b0;   done_q <= 1'b0;    coll_self_q <= 1'b0;  coll_wall_q <= 1'b0;
        end else if (bus.start) begin
            state_q <= IDLE;  head_ptr_q <= '0;  length_q <= LW'(1);  head_q <= INIT_POS;
            new_head_q <= '0; scan_len_q <= '0;  scan_k_q <= '0;
            grow_q <= 1'b0;   wall_q <= 1'b0;    dir_q <= 2'b00;
            busy_q <= 1'b0;   done_q <= 1'b0;    coll_self_q <= 1'b0;  coll_wall_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.step) begin
                    grow_q      <= bus.grow;
                    dir_q       <= bus.direction;
                    wall_q      <= bus.wall_mode;
                    coll_self_q <= 1'b0;
                    coll_wall_q <= 1'b0;
                    busy_q      <= 1'b1;
                    state_q     <= CALC;
                end
                CALC: begin
                    new_head_q <= new_head_d;
                    grow_q     <= eff_grow_d;
                    scan_len_q <= scan_len_d;
                    scan_k_q   <= '0;
                    if (wall_q && edge_d) begin
                        coll_wall_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (scan_len_d == '0) begin
                        state_q <= COMMIT;
                    end else begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (seg_hit) begin
                        coll_self_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (scan_last) begin
                        state_q <= COMMIT;
                    end else begin
                        scan_k_q <= scan_k_q + 1'b1;
                    end
                end
                COMMIT: begin
                    head_ptr_q <= head_ptr_d;
                    head_q     <= new_head_q;
                    if (grow_q) length_q <= length_q + 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Render port reads the committed body; during COMMIT it still sees the old ring.
    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            rd_pos_q   <= '0;
            rd_valid_q <= 1'b0;
        end else if (bus.start) begin
            rd_pos_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_pos_q   <= mem_q[ptr_sub(head_ptr_q, bus.rd_idx)];
            rd_valid_q <= (LW'(bus.rd_idx) < length_q);
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.collision_self = coll_self_q;
    assign bus.collision_wall = coll_wall_q;
    assign bus.full           = full_w;
    assign bus.head           = head_q;
    assign bus.length         = length_q;
    assign bus.rd_pos         = rd_pos_q;
    assign bus.rd_valid       = rd_valid_q;
endmodule

// File: tb/tb_snake_body_ring.sv
// Directed bench: three rings (64/0x1B, 64/0x00, 4/0x00) driven with hand-computed move sequences.
module tb_snake_body_ring;
    logic       clock = 1'b0;
    logic       restart = 1'b0;
    logic       start = 1'b0;
    logic       grow = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       wall = 1'b0;
    logic [5:0] rd_idx = '0;
    logic       step_a = 1'b0, step_b = 1'b0, step_c = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         lat;
    logic       seen_done;

    always #5 clock = ~clock;

    snake_body_ring_if #(.XBITS(3), .YBITS(3), .MAX_LEN(64)) ia ();
    snake_body_ring_if #(.XBITS(3), .YBITS(3), .MAX_LEN(64)) ib ();
    snake_body_ring_if #(.XBITS(3), .YBITS(3), .MAX_LEN(4))  ic ();

    assign ia.start = start;  assign ia.step = step_a;  assign ia.grow = grow;
    assign ia.direction = dir; assign ia.wall_mode = wall; assign ia.rd_idx = rd_idx;
    assign ib.start = start;  assign ib.step = step_b;  assign ib.grow = grow;
    assign ib.direction = dir; assign ib.wall_mode = wall; assign ib.rd_idx = rd_idx;
    assign ic.start = start;  assign ic.step = step_c;  assign ic.grow = grow;
    assign ic.direction = dir; assign ic.wall_mode = wall; assign ic.rd_idx = rd_idx[1:0];

    snake_body_ring #(.XBITS(3), .YBITS(3), .MAX_LEN(64), .INIT_POS(6'h1B))
        u_a (.clock(clock), .restart(restart), .bus(ia));
    snake_body_ring #(.XBITS(3), .YBITS(3), .MAX_LEN(64), .INIT_POS(6'h00))
        u_b (.clock(clock), .restart(restart), .bus(ib));
    snake_body_ring #(.XBITS(3), .YBITS(3), .MAX_LEN(4), .INIT_POS(6'h00))
        u_c (.clock(clock), .restart(restart), .bus(ic));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return ia.done;
            1:       return ib.done;
            default: return ic.done;
        endcase
    endfunction

    // Cycle 0 is the edge that samples step; lat is the first cycle where done reads 1 (-1 on timeout).
    task automatic do_step(input int sel, input logic g, input logic [1:0] d, input logic w,
                           output int l);
        @(negedge clock);
        grow = g; dir = d; wall = w;
        step_a = (sel == 0); step_b = (sel == 1); step_c = (sel == 2);
        @(posedge clock); #1;
        step_a = 1'b0; step_b = 1'b0; step_c = 1'b0;
        l = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clock); #1;
            if (done_of(sel)) begin l = c; break; end
        end
    endtask

    task automatic read_at(input logic [5:0] idx);
        @(negedge clock);
        rd_idx = idx;
        @(posedge clock); #1;
    endtask

    initial begin
        #1 restart = 1'b1;
        #3;
        chk("rst_head_a", ia.head, 32'h1B);
        chk("rst_len_a", ia.length, 1);
        chk("rst_busy_a", ia.busy, 0);
        chk("rst_done_a", ia.done, 0);
        chk("rst_flags_a", {ia.collision_self, ia.collision_wall}, 0);
        chk("rst_rdvalid_a", ia.rd_valid, 0);
        @(negedge clock) restart = 1'b0;

        read_at(6'd0);
        chk("rd0_pos_a", ia.rd_pos, 32'h1B);
        chk("rd0_valid_a", ia.rd_valid, 1);
        read_at(6'd1);
        chk("rd1_valid_a", ia.rd_valid, 0);

        do_step(0, 1'b0, 2'b00, 1'b0, lat);
        chk("movex_lat", lat, 3);
        chk("movex_head", ia.head, 32'h1C);
        chk("movex_len", ia.length, 1);
        chk("movex_flags", {ia.collision_self, ia.collision_wall}, 0);

        for (int i = 0; i < 3; i++) begin
            do_step(1, 1'b1, 2'b00, 1'b0, lat);
            chk("grow_lat", lat, 4 + i);
        end
        chk("grow_len", ib.length, 4);
        for (int i = 0; i < 4; i++) begin
            read_at(6'(i));
            chk("grow_rd", ib.rd_pos, 32'(3 - i));
        end
        do_step(1, 1'b1, 2'b00, 1'b0, lat);
        chk("grow4_lat", lat, 7);
        chk("grow4_len", ib.length, 5);
        for (int i = 0; i < 3; i++) begin
            do_step(1, 1'b0, 2'b00, 1'b0, lat);
            chk("plain_lat", lat, 7);
        end
        chk("plain_head", ib.head, 32'h07);

        do_step(1, 1'b0, 2'b00, 1'b1, lat);
        chk("wall_lat", lat, 2);
        chk("wall_flag", ib.collision_wall, 1);
        chk("wall_head", ib.head, 32'h07);
        chk("wall_len", ib.length, 5);
        do_step(1, 1'b0, 2'b00, 1'b0, lat);
        chk("wrap_lat", lat, 7);
        chk("wrap_head", ib.head, 32'h00);
        chk("wrap_flag", ib.collision_wall, 0);

        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        chk("start_head_b", ib.head, 32'h00);
        chk("start_len_b", ib.length, 1);

        do_step(1, 1'b1, 2'b00, 1'b0, lat);
        do_step(1, 1'b1, 2'b01, 1'b0, lat);
        do_step(1, 1'b1, 2'b10, 1'b0, lat);
        chk("body_lat", lat, 6);
        chk("body_head", ib.head, 32'h08);
        chk("body_len", ib.length, 4);

        do_step(1, 1'b0, 2'b00, 1'b0, lat);
        chk("self_k1_lat", lat, 4);
        chk("self_k1_flag", ib.collision_self, 1);
        chk("self_k1_head", ib.head, 32'h08);
        do_step(1, 1'b1, 2'b11, 1'b0, lat);
        chk("self_tail_lat", lat, 6);
        chk("self_tail_flag", ib.collision_self, 1);
        chk("self_tail_len", ib.length, 4);
        do_step(1, 1'b0, 2'b11, 1'b0, lat);
        chk("tail_move_lat", lat, 6);
        chk("tail_move_flag", ib.collision_self, 0);
        chk("tail_move_head", ib.head, 32'h00);
        chk("tail_move_len", ib.length, 4);
        read_at(6'd3);
        chk("tail_move_rd3", ib.rd_pos, 32'h01);

        for (int i = 0; i < 3; i++) begin
            do_step(2, 1'b1, 2'b00, 1'b0, lat);
            chk("c_grow_lat", lat, 4 + i);
        end
        chk("c_full", ic.full, 1);
        chk("c_len", ic.length, 4);
        do_step(2, 1'b1, 2'b00, 1'b0, lat);
        chk("c_fullgrow_lat", lat, 6);
        chk("c_fullgrow_len", ic.length, 4);
        chk("c_fullgrow_full", ic.full, 1);
        chk("c_fullgrow_head", ic.head, 32'h04);
        read_at(6'd3);
        chk("c_tail_rd", ic.rd_pos, 32'h01);
        read_at(6'd0);
        chk("c_head_rd", ic.rd_pos, 32'h04);

        @(negedge clock);
        start = 1'b1; step_c = 1'b1; grow = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; step_c = 1'b0;
        chk("startprio_busy", ic.busy, 0);
        chk("startprio_head", ic.head, 32'h00);
        chk("startprio_len", ic.length, 1);

        @(negedge clock);
        grow = 1'b1; dir = 2'b00; step_c = 1'b1;
        @(posedge clock); #1 step_c = 1'b0;
        @(posedge clock); #1;
        chk("scan_busy", ic.busy, 1);
        #2 restart = 1'b1;
        #1;
        chk("abort_busy", ic.busy, 0);
        chk("abort_head", ic.head, 32'h00);
        chk("abort_len", ic.length, 1);
        chk("abort_head_a", ia.head, 32'h1B);
        @(negedge clock) restart = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            if (ic.done) seen_done = 1'b1;
        end
        chk("abort_no_done", seen_done, 0);
        chk("abort_head_after", ic.head, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
